// File: rtl/register_file_param.sv
// register_file_param: dual-read register file with write bypass, optional zero register, valid bits and a clear sweep
module register_file_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              replaceEn,
    input  logic [DATA_W-1:0] replaceData,
    input  logic [ADDR_W-1:0] replaceSel,
    input  logic [ADDR_W-1:0] A_sel,
    input  logic [ADDR_W-1:0] B_sel,
    input  logic              clearReq,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              A_valid,
    output logic              B_valid,
    output logic              busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = ZERO_REG != 0;
    localparam bit BP    = BYPASS != 0;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  r_state, w_next;
    logic [ADDR_W-1:0]       r_clr_idx;
    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [DEPTH-1:0]        r_valid;
    logic                    w_wr_ok, w_wr_eff, w_a_zero, w_b_zero, w_a_fwd, w_b_fwd;

    assign w_wr_ok  = replaceEn && r_state == IDLE && !clearReq && !reset;
    assign w_wr_eff = w_wr_ok && !(ZR && replaceSel == '0);
    assign w_a_zero = ZR && A_sel == '0;
    assign w_b_zero = ZR && B_sel == '0;
    assign w_a_fwd  = BP && w_wr_ok && replaceSel == A_sel;
    assign w_b_fwd  = BP && w_wr_ok && replaceSel == B_sel;

    always_comb begin
        A       = w_a_zero ? '0   : w_a_fwd ? replaceData : r_mem[A_sel];
        A_valid = w_a_zero ? 1'b1 : w_a_fwd ? 1'b1        : r_valid[A_sel];
        B       = w_b_zero ? '0   : w_b_fwd ? replaceData : r_mem[B_sel];
        B_valid = w_b_zero ? 1'b1 : w_b_fwd ? 1'b1        : r_valid[B_sel];
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && clearReq)
            w_next = CLEAR;
        else if (r_state == CLEAR && r_clr_idx == ADDR_W'(DEPTH - 1))
            w_next = IDLE;
    end

    assign busy = r_state == CLEAR;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_clr_idx <= '0;
            r_mem     <= '{default: '0};
            r_valid   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == CLEAR) begin
                r_mem[r_clr_idx]   <= '0;
                r_valid[r_clr_idx] <= 1'b0;
                r_clr_idx          <= r_clr_idx + 1'b1;
            end else if (clearReq) begin
                r_clr_idx <= '0;
            end else if (w_wr_eff) begin
                r_mem[replaceSel]   <= replaceData;
                r_valid[replaceSel] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param: directed checks of three register file variants sharing one stimulus
module tb_register_file_param;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       replaceEn = 1'b0;
    logic [7:0] replaceData = '0;
    logic [3:0] replaceSel = '0;
    logic [3:0] A_sel = '0;
    logic [3:0] B_sel = '0;
    logic       clearReq = 1'b0;
    logic [7:0] a, b, a_nb, b_nb, a_z, b_z;
    logic       av, bv, busy, av_nb, bv_nb, busy_nb, av_z, bv_z, busy_z;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    register_file_param dut (
        .clk(clk), .reset(reset), .replaceEn(replaceEn), .replaceData(replaceData),
        .replaceSel(replaceSel), .A_sel(A_sel), .B_sel(B_sel), .clearReq(clearReq),
        .A(a), .B(b), .A_valid(av), .B_valid(bv), .busy(busy));

    register_file_param #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .replaceEn(replaceEn), .replaceData(replaceData),
        .replaceSel(replaceSel), .A_sel(A_sel), .B_sel(B_sel), .clearReq(clearReq),
        .A(a_nb), .B(b_nb), .A_valid(av_nb), .B_valid(bv_nb), .busy(busy_nb));

    register_file_param #(.ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .replaceEn(replaceEn), .replaceData(replaceData),
        .replaceSel(replaceSel), .A_sel(A_sel), .B_sel(B_sel), .clearReq(clearReq),
        .A(a_z), .B(b_z), .A_valid(av_z), .B_valid(bv_z), .busy(busy_z));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] sel, input logic [7:0] data);
        replaceEn = 1'b1;
        replaceSel = sel;
        replaceData = data;
        tick();
        replaceEn = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        A_sel = 4'd0;
        B_sel = 4'd3;
        #1;
        checks++;
        if ({a, av, b, bv, busy} !== 19'h0) begin
            errors++;
            $display("FAIL reset_out got A=%h Av=%b B=%h Bv=%b busy=%b want all 0", a, av, b, bv, busy);
        end
        checks++;
        if ({a_z, av_z, bv_z} !== 10'b0000_0000_10) begin
            errors++;
            $display("FAIL reset_zero_reg got A=%h Av=%b Bv=%b want 00 1 0", a_z, av_z, bv_z);
        end
    endtask

    task automatic test_write_read();
        write(4'd0, 8'hAA);
        write(4'd1, 8'hBB);
        write(4'd2, 8'hCC);
        A_sel = 4'd2;
        B_sel = 4'd1;
        #1;
        checks++;
        if ({a, av, b, bv} !== {8'hCC, 1'b1, 8'hBB, 1'b1}) begin
            errors++;
            $display("FAIL read_2_1 got A=%h Av=%b B=%h Bv=%b want CC 1 BB 1", a, av, b, bv);
        end
        A_sel = 4'd5;
        B_sel = 4'd0;
        #1;
        checks++;
        if ({a, av} !== 9'h0) begin
            errors++;
            $display("FAIL read_unwritten got A=%h Av=%b want 00 0", a, av);
        end
        checks++;
        if ({b, bv} !== {8'hAA, 1'b1}) begin
            errors++;
            $display("FAIL read_reg0 got B=%h Bv=%b want AA 1", b, bv);
        end
        checks++;
        if ({b_z, bv_z} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL zero_reg_ignores_write got B=%h Bv=%b want 00 1", b_z, bv_z);
        end
    endtask

    task automatic test_bypass();
        replaceEn = 1'b1;
        replaceSel = 4'd3;
        replaceData = 8'h5A;
        A_sel = 4'd3;
        B_sel = 4'd3;
        #1;
        checks++;
        if ({a, av, b, bv} !== {8'h5A, 1'b1, 8'h5A, 1'b1}) begin
            errors++;
            $display("FAIL bypass_pre_edge got A=%h Av=%b B=%h Bv=%b want 5A 1 5A 1", a, av, b, bv);
        end
        checks++;
        if ({a_nb, av_nb} !== 9'h0) begin
            errors++;
            $display("FAIL no_bypass_pre_edge got A=%h Av=%b want 00 0", a_nb, av_nb);
        end
        tick();
        replaceEn = 1'b0;
        #1;
        checks++;
        if ({a_nb, av_nb, b_nb, bv_nb} !== {8'h5A, 1'b1, 8'h5A, 1'b1}) begin
            errors++;
            $display("FAIL no_bypass_post_edge got A=%h Av=%b B=%h Bv=%b want 5A 1 5A 1", a_nb, av_nb, b_nb, bv_nb);
        end
    endtask

    task automatic test_zero_reg();
        replaceEn = 1'b1;
        replaceSel = 4'd0;
        replaceData = 8'hFF;
        A_sel = 4'd0;
        #1;
        checks++;
        if ({a_z, av_z} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL zero_reg_no_bypass got A=%h Av=%b want 00 1", a_z, av_z);
        end
        tick();
        replaceEn = 1'b0;
        #1;
        checks++;
        if ({a_z, av_z, a} !== {8'h00, 1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL zero_reg_after got Az=%h Avz=%b A=%h want 00 1 FF", a_z, av_z, a);
        end
        write(4'd1, 8'hFF);
        A_sel = 4'd1;
        #1;
        checks++;
        if ({a_z, av_z} !== {8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL zero_reg_reg1 got A=%h Av=%b want FF 1", a_z, av_z);
        end
    endtask

    task automatic test_clear();
        int n = 0;
        int bad = 0;
        for (int i = 0; i < 16; i++) write(4'(i), 8'h10 + 8'(i));
        clearReq = 1'b1;
        tick();
        clearReq = 1'b0;
        while (busy && n < 40) begin
            replaceEn = 1'b0;
            if (n == 4) begin
                A_sel = 4'd3;
                B_sel = 4'd4;
                #1;
                checks++;
                if ({a, av, b, bv} !== {8'h00, 1'b0, 8'h14, 1'b1}) begin
                    errors++;
                    $display("FAIL mid_sweep got A=%h Av=%b B=%h Bv=%b want 00 0 14 1", a, av, b, bv);
                end
                replaceEn = 1'b1;
                replaceSel = 4'd7;
                replaceData = 8'h77;
                A_sel = 4'd7;
                #1;
                checks++;
                if ({a, av} !== {8'h17, 1'b1}) begin
                    errors++;
                    $display("FAIL busy_write_bypass got A=%h Av=%b want 17 1", a, av);
                end
            end
            n++;
            tick();
        end
        replaceEn = 1'b0;
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL busy_cycles got %0d want 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            A_sel = 4'(i);
            #1;
            if ({a, av} !== 9'h0) begin
                bad++;
                $display("FAIL post_clear reg %0d got A=%h Av=%b want 00 0", i, a, av);
            end
        end
        checks++;
        if (bad != 0) errors++;
        write(4'd8, 8'h88);
        A_sel = 4'd8;
        #1;
        checks++;
        if ({a, av} !== {8'h88, 1'b1}) begin
            errors++;
            $display("FAIL first_write_after_clear got A=%h Av=%b want 88 1", a, av);
        end
    endtask

    task automatic test_clear_write_collision();
        int n = 0;
        replaceEn = 1'b1;
        replaceSel = 4'd6;
        replaceData = 8'h66;
        clearReq = 1'b1;
        A_sel = 4'd6;
        #1;
        checks++;
        if ({a, av} !== 9'h0) begin
            errors++;
            $display("FAIL collision_no_bypass got A=%h Av=%b want 00 0", a, av);
        end
        tick();
        replaceEn = 1'b0;
        clearReq = 1'b0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if ({a, av, busy} !== 10'h0) begin
            errors++;
            $display("FAIL collision_dropped got A=%h Av=%b busy=%b want 00 0 0", a, av, busy);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int bad = 0;
        write(4'd12, 8'hC0);
        clearReq = 1'b1;
        tick();
        clearReq = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_busy got %b want 0", busy);
        end
        for (int i = 0; i < 16; i++) begin
            A_sel = 4'(i);
            #1;
            if ({a, av} !== 9'h0) begin
                bad++;
                $display("FAIL reset_abort reg %0d got A=%h Av=%b want 00 0", i, a, av);
            end
        end
        checks++;
        if (bad != 0) errors++;
        replaceEn = 1'b1;
        replaceSel = 4'd2;
        replaceData = 8'h42;
        A_sel = 4'd2;
        tick();
        replaceEn = 1'b0;
        #1;
        checks++;
        if ({a_nb, av_nb} !== {8'h42, 1'b1}) begin
            errors++;
            $display("FAIL write_after_reset got A=%h Av=%b want 42 1", a_nb, av_nb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        tick();
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_clear_write_collision();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
